// File: rtl/muldiv_unit.sv
// Multi-cycle MIPS32 multiply/divide unit; writer side of HI/LO.
// Multiplies finish after MUL_LATENCY cycles, divides after 33 (32-step restoring).
module muldiv_unit #(
  parameter int MUL_LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] opa,
  input  logic [31:0] opb,
  input  logic        cancel,
  input  logic [63:0] hilo_rdata,
  output logic        busy,
  output logic        stall,
  output logic        hilo_wen,
  output logic [63:0] hilo_wdata
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t      state, state_nxt;
  logic [2:0]  op_q;
  logic [31:0] a_q, b_q;
  logic [63:0] acc_q;
  logic [4:0]  cnt;
  logic [31:0] rem_q, quo_q, dvs_q;

  logic        accept, is_div;
  logic [2:0]  src_op;
  logic [31:0] src_a, src_b;
  logic [63:0] src_acc, ext_a, ext_b, prod, mul_res;
  logic        a_sgn, b_sgn;
  logic [31:0] dvd_mag, dvs_mag;
  logic [32:0] shifted;
  logic        ge;
  logic [31:0] rem_nxt, quo_nxt, q_fin, r_fin;
  logic [63:0] div_res;

  assign accept = (state == IDLE || state == DONE) && start && !cancel;
  assign is_div = (op[2:1] == 2'b01);

  always_comb begin
    state_nxt = state;
    if (cancel)
      state_nxt = IDLE;
    else if (accept)
      state_nxt = is_div ? DIV : ((MUL_LATENCY == 1) ? DONE : MUL);
    else begin
      case (state)
        MUL:     if (cnt == 5'd0) state_nxt = DONE;
        DIV:     if (cnt == 5'd0) state_nxt = DONE;
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign stall    = (state == MUL) || (state == DIV) || accept;
  assign hilo_wen = (state == DONE) && !cancel;

  // Live inputs feed the multiplier in the accept cycle so MUL_LATENCY=1 works.
  assign src_op  = accept ? op : op_q;
  assign src_a   = accept ? opa : a_q;
  assign src_b   = accept ? opb : b_q;
  assign src_acc = accept ? hilo_rdata : acc_q;
  assign ext_a   = {{32{!src_op[0] & src_a[31]}}, src_a};
  assign ext_b   = {{32{!src_op[0] & src_b[31]}}, src_b};
  assign prod    = ext_a * ext_b;

  always_comb begin
    mul_res = prod;
    if (src_op[2] && !src_op[1])     mul_res = src_acc + prod;
    else if (src_op[2] && src_op[1]) mul_res = src_acc - prod;
  end

  assign a_sgn   = !op[0] && opa[31];
  assign b_sgn   = !op[0] && opb[31];
  assign dvd_mag = a_sgn ? -opa : opa;
  assign dvs_mag = b_sgn ? -opb : opb;

  // One restoring step; a zero divisor just shifts the dividend into rem.
  assign shifted = {rem_q, quo_q[31]};
  assign ge      = shifted >= {1'b0, dvs_q};
  assign rem_nxt = ge ? (shifted[31:0] - dvs_q) : shifted[31:0];
  assign quo_nxt = {quo_q[30:0], ge};

  assign q_fin = (!op_q[0] && (a_q[31] ^ b_q[31])) ? -quo_nxt : quo_nxt;
  assign r_fin = (!op_q[0] && a_q[31]) ? -rem_nxt : rem_nxt;
  assign div_res = (b_q == 32'd0) ? {a_q, 32'hFFFF_FFFF} : {r_fin, q_fin};

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      hilo_wdata <= 64'd0;
      op_q       <= 3'd0;
      a_q        <= 32'd0;
      b_q        <= 32'd0;
      acc_q      <= 64'd0;
      cnt        <= 5'd0;
      rem_q      <= 32'd0;
      quo_q      <= 32'd0;
      dvs_q      <= 32'd0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != IDLE);
      if (accept) begin
        op_q  <= op;
        a_q   <= opa;
        b_q   <= opb;
        acc_q <= hilo_rdata;
        cnt   <= is_div ? 5'd31 : ((MUL_LATENCY > 1) ? 5'(MUL_LATENCY - 2) : 5'd0);
        rem_q <= 32'd0;
        quo_q <= dvd_mag;
        dvs_q <= dvs_mag;
      end else if (state == MUL || state == DIV) begin
        cnt <= cnt - 5'd1;
        if (state == DIV) begin
          rem_q <= rem_nxt;
          quo_q <= quo_nxt;
        end
      end
      if (state_nxt == DONE)
        hilo_wdata <= (state == DIV) ? div_res : mul_res;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases plus random ops
// compared against a plain-arithmetic reference model.
module tb_muldiv_unit;
  localparam int ML = 2;

  logic        clk, rst, start, cancel, busy, stall, hilo_wen;
  logic [2:0]  op;
  logic [31:0] opa, opb;
  logic [63:0] hilo_rdata, hilo_wdata;
  int nvec = 0, nerr = 0;

  muldiv_unit #(.MUL_LATENCY(ML)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .opa(opa), .opb(opb),
    .cancel(cancel), .hilo_rdata(hilo_rdata), .busy(busy), .stall(stall),
    .hilo_wen(hilo_wen), .hilo_wdata(hilo_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a, b,
                                        input logic [63:0] hl);
    logic [63:0] p;
    longint sa, sb, q, r;
    if (o[2:1] == 2'b01) begin
      if (b == 32'd0) return {a, 32'hFFFF_FFFF};
      if (!o[0]) begin sa = longint'($signed(a)); sb = longint'($signed(b)); end
      else       begin sa = longint'({32'd0, a}); sb = longint'({32'd0, b}); end
      q = sa / sb;
      r = sa % sb;
      return {r[31:0], q[31:0]};
    end
    if (!o[0]) p = longint'($signed(a)) * longint'($signed(b));
    else       p = {32'd0, a} * {32'd0, b};
    case (o[2:1])
      2'b10:   return hl + p;
      2'b11:   return hl - p;
      default: return p;
    endcase
  endfunction

  // Called at a negedge with the DUT in IDLE or DONE; returns at the DONE negedge.
  task automatic do_op(input logic [2:0] o, input logic [31:0] a, b, input logic [63:0] hl);
    int lat;
    logic [63:0] e;
    lat = (o[2:1] == 2'b01) ? 33 : ML;
    e = model(o, a, b, hl);
    start = 1'b1; op = o; opa = a; opb = b; hilo_rdata = hl;
    #1 chk("stall_accept", stall, 1'b1);
    @(posedge clk); @(negedge clk);
    start = 1'b0; op = 3'($urandom); opa = $urandom; opb = $urandom;
    hilo_rdata = {$urandom, $urandom};
    #1;
    for (int k = 1; k <= lat; k++) begin
      chk("busy", busy, 1'b1);
      chk("wen", hilo_wen, k == lat);
      chk("stall", stall, k < lat);
      if (k == lat) chk("wdata", hilo_wdata, e);
      else @(negedge clk);
    end
  endtask

  task automatic idle_cyc();
    @(posedge clk); @(negedge clk);
    chk("idle_busy", busy, 1'b0);
    chk("idle_wen", hilo_wen, 1'b0);
  endtask

  task automatic quiet(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("no_wen", hilo_wen, 1'b0);
    end
  endtask

  initial begin
    logic [2:0]  ro;
    logic [31:0] ra, rb;
    rst = 1'b1; start = 1'b0; cancel = 1'b0; op = 3'd0;
    opa = 32'd0; opb = 32'd0; hilo_rdata = 64'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_wen", hilo_wen, 1'b0);
    chk("rst_wdata", hilo_wdata, 64'd0);
    chk("rst_stall", stall, 1'b0);
    rst = 1'b0;

    do_op(3'b000, 32'hFFFF_FFFE, 32'd3, 64'd0);
    chk("mult_neg", hilo_wdata, 64'hFFFF_FFFF_FFFF_FFFA);
    idle_cyc();
    do_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd0);
    chk("multu_max", hilo_wdata, 64'hFFFF_FFFE_0000_0001);
    idle_cyc();
    do_op(3'b101, 32'd2, 32'd3, 64'h0000_0001_FFFF_FFFF);
    chk("maddu", hilo_wdata, 64'h0000_0002_0000_0005);
    idle_cyc();
    do_op(3'b110, 32'd4, 32'hFFFF_FFFF, 64'd10);
    chk("msub", hilo_wdata, 64'd14);
    idle_cyc();
    do_op(3'b010, 32'hFFFF_FFF9, 32'd2, 64'd0);
    chk("div_neg", hilo_wdata, 64'hFFFF_FFFF_FFFF_FFFD);
    idle_cyc();
    do_op(3'b011, 32'd7, 32'd2, 64'd0);
    chk("divu", hilo_wdata, 64'h0000_0001_0000_0003);
    idle_cyc();
    do_op(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 64'd0);
    chk("div_ovf", hilo_wdata, 64'h0000_0000_8000_0000);
    idle_cyc();
    do_op(3'b011, 32'd5, 32'd0, 64'd0);
    chk("divu_zero", hilo_wdata, 64'h0000_0005_FFFF_FFFF);
    idle_cyc();

    // Back-to-back: MULT accepted in the DIV's DONE cycle, bypass carries DIV result.
    do_op(3'b010, 32'd100, 32'd7, 64'd0);
    do_op(3'b100, 32'd5, 32'd6, 64'h0000_0002_0000_000E);
    chk("b2b_madd", hilo_wdata, 64'h0000_0002_0000_002C);
    idle_cyc();

    // Cancel in cycle 10 of a DIV.
    start = 1'b1; op = 3'b010; opa = 32'd1000; opb = 32'd3;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    for (int k = 1; k < 10; k++) begin
      chk("cancel_pre_wen", hilo_wen, 1'b0);
      @(negedge clk);
    end
    cancel = 1'b1;
    #1 chk("cancel_wen", hilo_wen, 1'b0);
    @(negedge clk);
    cancel = 1'b0;
    chk("cancel_busy", busy, 1'b0);
    quiet(35);

    // start and cancel together: nothing accepted.
    start = 1'b1; cancel = 1'b1; op = 3'b000;
    #1 chk("sc_stall", stall, 1'b0);
    @(negedge clk);
    start = 1'b0; cancel = 1'b0;
    chk("sc_busy", busy, 1'b0);
    quiet(4);

    // Reset mid-DIV.
    start = 1'b1; op = 3'b011; opa = 32'd99; opb = 32'd4;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstmid_busy", busy, 1'b0);
    chk("rstmid_wdata", hilo_wdata, 64'd0);
    quiet(35);

    // Random ops, sometimes chained from DONE.
    for (int n = 0; n < 40; n++) begin
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: rb = 32'hFFFF_FFFF;
        2: ra = 32'h8000_0000;
        3: rb = 32'($urandom_range(1, 20));
        default: ;
      endcase
      do_op(ro, ra, rb, {$urandom, $urandom});
      if ($urandom_range(0, 1) == 0) idle_cyc();
    end
    idle_cyc();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Multi-cycle multiply/divide unit for the MIPS32 execute stage.
- It is the writer side of the HI/LO register: it produces the hilo_wen / hilo_wdata pair consumed by the HI/LO + LLbit block.
- It reads the current HI:LO (already bypassed) for accumulate ops.
- It stalls the pipeline while an operation is in flight.

Parameters:
- MUL_LATENCY, 2, cycles from accept to the hilo_wen pulse for multiply-class ops; legal range 1..4.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous active-high reset
- start  in  1  issue request from execute stage
- op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MADD, 101 MADDU, 110 MSUB, 111 MSUBU
- opa  in  32  rs operand (dividend / multiplicand)
- opb  in  32  rt operand (divisor / multiplier)
- cancel  in  1  pipeline flush (exception/eret); aborts the current op
- hilo_rdata  in  64  current {HI,LO} including bypass
- busy  out  1  registered; high in any state other than IDLE
- stall  out  1  combinational pipeline stall request
- hilo_wen  out  1  one-cycle HI/LO write strobe
- hilo_wdata  out  64  {HI,LO} result

Behaviour:
- Reset: clk and rst only; rst synchronous and active-high, and it overrides start and cancel.
  - State goes to IDLE.
  - busy=0, hilo_wen=0, hilo_wdata=0; all internal registers cleared.
- States and transitions:
  - IDLE: on start&!cancel, accept the op → MUL (op≠01x) or DIV (op=01x).
  - MUL: count MUL_LATENCY-1 cycles → DONE.
  - DIV: 32 restoring iterations, one quotient bit per cycle, MSB first → DONE.
  - DONE: asserts hilo_wen → IDLE, or directly back to MUL/DIV if start&!cancel.
- Accept: opa, opb, op and hilo_rdata are latched in the accept cycle. Later changes to these inputs are ignored.
- start outside IDLE/DONE is ignored. The pipeline holds it via stall.
- Latency, with the accept cycle as cycle 0:
  - hilo_wen is high in cycle MUL_LATENCY for multiply ops.
  - hilo_wen is high in cycle 33 for divides, including divide-by-zero. Latency is fixed.
- stall = (state∈{MUL,DIV}) | (state∈{IDLE,DONE} & start & !cancel).
  - stall is low in the DONE cycle unless a new op is accepted there.
- hilo_wen = (state==DONE) & !cancel. hilo_wdata holds its value until the next DONE.
- Multiply: full 64-bit product.
  - Signed for MULT/MADD/MSUB; unsigned for the U variants.
  - MADD*: result = latched HI:LO + product. MSUB*: result = latched HI:LO − product.
  - Arithmetic is mod 2^64; no overflow trap.
- Divide: operates on magnitudes.
  - Signed: quotient negated if the operand signs differ; remainder takes the sign of the dividend.
  - HI = remainder, LO = quotient.
  - 0x80000000 / 0xFFFFFFFF (DIV) → LO=0x80000000, HI=0.
  - Divide-by-zero (opb=0, either op): LO=0xFFFFFFFF, HI=opa. Latency is still 33 cycles.
- Cancel:
  - Takes effect in the same cycle: any state → IDLE next cycle.
  - No hilo_wen in that cycle or after.
  - start in the same cycle is not accepted.
- Back-to-back ops:
  - An op accepted in the DONE cycle latches hilo_rdata from the bypass.
  - That bypass already reflects the write occurring in the same cycle.

Test Plan:
- Reset, then MULT opa=0xFFFFFFFE(−2), opb=3 → exactly one hilo_wen in cycle 2, hilo_wdata=0xFFFFFFFF_FFFFFFFA; stall high cycles 0–1, low in cycle 2.
- MULTU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE_00000001. Then MADDU 2×3 with hilo_rdata=0x00000001_FFFFFFFF → 0x00000002_00000005.
- DIV opa=−7 (0xFFFFFFF9), opb=2 → hilo_wen only in cycle 33, HI=0xFFFFFFFF(−1), LO=0xFFFFFFFD(−3), busy high cycles 1–33. DIVU 7/2 → HI=1, LO=3.
- Boundaries:
  - DIV 0x80000000/0xFFFFFFFF → HI=0, LO=0x80000000.
  - DIVU 5/0 → HI=5, LO=0xFFFFFFFF at cycle 33.
- cancel asserted in cycle 10 of a DIV → IDLE in cycle 11, no hilo_wen ever. start&cancel in the same cycle → nothing accepted, stall=0.
- New MULT presented in the DONE cycle of a DIV → DIV write occurs, MULT accepted, its write follows MUL_LATENCY cycles later. rst pulsed mid-DIV → busy=0 and no write.
